ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 19, SHALL set the data word width.
REQ-002 Parameter A_WIDTH, default 5, SHALL set the address width.
REQ-003 Parameter A_MAX, default 32 (2^A_WIDTH), SHALL set the number of words swept by clear.
REQ-004 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 mN_rd_valid / mN_rd_ready  input / output  1  SHALL be the read-request handshake of requester N (N = 0, 1).
REQ-007 mN_rd_addr  input  A_WIDTH  SHALL be requester N's read address.
REQ-008 mN_rsp_valid / mN_rsp_data  output  1 / D_WIDTH  SHALL be requester N's read response.
REQ-009 mN_wr_valid / mN_wr_ready  input / output  1  SHALL be the write-request handshake of requester N.
REQ-010 mN_wr_addr / mN_wr_data  input  A_WIDTH / D_WIDTH  SHALL be requester N's write address and data.
REQ-011 clear_start  input  1  SHALL request a zero-fill of all A_MAX words; clear_busy / clear_done  output  1 / 1  SHALL report the sweep.
REQ-012 ram_address_write, ram_data_write, ram_write_enable, ram_address_read  output  A_WIDTH, D_WIDTH, 1, A_WIDTH  SHALL drive the RAM ports; ram_data_read  input  D_WIDTH  SHALL be the RAM's combinational read data.

Function
REQ-013 Read port and write port SHALL be arbitrated independently; one read and one write MAY complete in the same cycle.
REQ-014 Each port SHALL use 2-way round-robin: sole requester wins; if both request, the requester other than the last winner on that port wins.
REQ-015 mN_*_ready SHALL be combinational = grant to N AND state == IDLE; a handshake occurs when valid and ready are both high.
REQ-016 Requesters SHALL hold valid/addr/data stable until ready; the arbiter SHALL not require valid to wait for ready.
REQ-017 Write handshake: ram_write_enable = 1 with the winner's addr/data that cycle; memory updates at that edge (0-cycle latency).
REQ-018 Read handshake: ram_address_read = winner's addr; ram_data_read registered into mN_rsp_data at that edge; mN_rsp_valid high exactly the next cycle (1-cycle latency); back-to-back reads SHALL sustain 1 per cycle.
REQ-019 Read and write to the same address in the same cycle SHALL return the pre-write (old) data; no forwarding.
REQ-020 mN_rsp_data SHALL hold its last value when mN_rsp_valid = 0.
REQ-021 FSM states IDLE, CLEAR; IDLE -> CLEAR on clear_start; CLEAR -> IDLE after the write to address A_MAX-1.
REQ-022 In CLEAR: counter 0..A_MAX-1 incrementing each cycle, ram_write_enable = 1, ram_data_write = 0, all ready = 0, clear_busy = 1; sweep takes exactly A_MAX cycles.
REQ-023 clear_done SHALL pulse 1 cycle on the CLEAR -> IDLE transition; clear_start while in CLEAR SHALL be ignored.
REQ-024 clear_start in the same cycle as pending requests SHALL win: no handshake that cycle.
REQ-025 Round-robin pointers SHALL not advance in CLEAR or on cycles without a handshake on that port.
REQ-026 When idle with no write handshake, ram_write_enable SHALL be 0.

Reset
REQ-027 On reset: state IDLE, counter 0, both round-robin pointers favour requester 0, all rsp_valid 0, rsp_data 0, clear_busy 0, clear_done 0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sweep with no clear_done pulse; remaining words are not zeroed by this block.

Structure
REQ-029 Package mem_ctrl_pkg SHALL hold D_WIDTH/A_WIDTH/A_MAX defaults and the FSM state enum.
REQ-030 Sub-module rr_arbiter_2 (2-requester round-robin with grant/advance inputs) SHALL be instanced twice, once per RAM port.
REQ-031 The RAM SHALL be external; this block contains no storage array.

Verification
REQ-032 m0 writes 0x1ABCD to addr 3, then m1 reads addr 3 -> m1_rsp_valid one cycle later with data 0x1ABCD.
REQ-033 m0 and m1 both hold wr_valid for 4 cycles after reset -> grants alternate m0, m1, m0, m1.
REQ-034 Same cycle: m0 writes 0x00055 to addr 7 (old 0x00011), m1 reads addr 7 -> m1_rsp_data 0x00011; next read returns 0x00055.
REQ-035 clear_start with pending m0 read -> 32 cycles busy, ready 0 throughout, clear_done pulse, then all 32 addresses read 0 and the m0 read completes.
REQ-036 Reset at clear cycle 10 -> no clear_done, state IDLE, addresses 10..31 retain their prior data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths and FSM state type for the RAM arbiter
package mem_ctrl_pkg;

    localparam int D_WIDTH_DEF = 19;
    localparam int A_WIDTH_DEF = 5;
    localparam int A_MAX_DEF   = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-requester round-robin arbiter; pointer moves only on advance
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // favour names the requester that wins a tie; it flips away from each accepted winner
    logic favour;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || !favour)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            favour <= 1'b0;
        end else if (advance) begin
            favour <= grant[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master arbiter for an external 1R1W RAM with zero-fill sweep
module ram_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int A_MAX   = A_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_rd_valid,
    output logic               m0_rd_ready,
    input  logic [A_WIDTH-1:0] m0_rd_addr,
    output logic               m0_rsp_valid,
    output logic [D_WIDTH-1:0] m0_rsp_data,
    input  logic               m0_wr_valid,
    output logic               m0_wr_ready,
    input  logic [A_WIDTH-1:0] m0_wr_addr,
    input  logic [D_WIDTH-1:0] m0_wr_data,
    input  logic               m1_rd_valid,
    output logic               m1_rd_ready,
    input  logic [A_WIDTH-1:0] m1_rd_addr,
    output logic               m1_rsp_valid,
    output logic [D_WIDTH-1:0] m1_rsp_data,
    input  logic               m1_wr_valid,
    output logic               m1_wr_ready,
    input  logic [A_WIDTH-1:0] m1_wr_addr,
    input  logic [D_WIDTH-1:0] m1_wr_data,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(A_MAX - 1);

    state_t             state;
    logic [A_WIDTH-1:0] count;
    logic [1:0]         rd_grant;
    logic [1:0]         wr_grant;
    logic [1:0]         rd_fire;
    logic [1:0]         wr_fire;
    logic               accept;

    // a clear request takes priority over any pending transfer in the same cycle
    assign accept = (state == IDLE) && !clear_start && !reset;

    assign m0_rd_ready = rd_grant[0] && accept;
    assign m1_rd_ready = rd_grant[1] && accept;
    assign m0_wr_ready = wr_grant[0] && accept;
    assign m1_wr_ready = wr_grant[1] && accept;

    assign rd_fire = {m1_rd_valid && m1_rd_ready, m0_rd_valid && m0_rd_ready};
    assign wr_fire = {m1_wr_valid && m1_wr_ready, m0_wr_valid && m0_wr_ready};

    rr_arbiter_2 u_rd_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({m1_rd_valid, m0_rd_valid}),
        .advance (|rd_fire),
        .grant   (rd_grant)
    );

    rr_arbiter_2 u_wr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({m1_wr_valid, m0_wr_valid}),
        .advance (|wr_fire),
        .grant   (wr_grant)
    );

    assign ram_address_read = rd_grant[1] ? m1_rd_addr : m0_rd_addr;

    // reset gates the sweep write so an aborted clear never touches the word under the counter
    always_comb begin
        ram_write_enable  = 1'b0;
        ram_address_write = wr_grant[1] ? m1_wr_addr : m0_wr_addr;
        ram_data_write    = wr_grant[1] ? m1_wr_data : m0_wr_data;
        if (state == CLEAR) begin
            ram_write_enable  = !reset;
            ram_address_write = count;
            ram_data_write    = '0;
        end else if (|wr_fire) begin
            ram_write_enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_data  <= '0;
            m1_rsp_data  <= '0;
        end else begin
            clear_done   <= 1'b0;
            m0_rsp_valid <= rd_fire[0];
            m1_rsp_valid <= rd_fire[1];
            if (rd_fire[0]) m0_rsp_data <= ram_data_read;
            if (rd_fire[1]) m1_rsp_data <= ram_data_read;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        count      <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (count == LAST_ADDR) begin
                        state      <= IDLE;
                        count      <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        count <= count + A_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_rd_valid, m0_rd_ready, m0_rsp_valid, m0_wr_valid, m0_wr_ready;
    logic        m1_rd_valid, m1_rd_ready, m1_rsp_valid, m1_wr_valid, m1_wr_ready;
    logic [4:0]  m0_rd_addr, m0_wr_addr, m1_rd_addr, m1_wr_addr;
    logic [18:0] m0_rsp_data, m0_wr_data, m1_rsp_data, m1_wr_data;
    logic        clear_start, clear_busy, clear_done;
    logic [4:0]  ram_address_write, ram_address_read;
    logic [18:0] ram_data_write, ram_data_read;
    logic        ram_write_enable;
    logic        fill_req;
    logic [18:0] mem [0:31];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .m0_rd_valid       (m0_rd_valid),
        .m0_rd_ready       (m0_rd_ready),
        .m0_rd_addr        (m0_rd_addr),
        .m0_rsp_valid      (m0_rsp_valid),
        .m0_rsp_data       (m0_rsp_data),
        .m0_wr_valid       (m0_wr_valid),
        .m0_wr_ready       (m0_wr_ready),
        .m0_wr_addr        (m0_wr_addr),
        .m0_wr_data        (m0_wr_data),
        .m1_rd_valid       (m1_rd_valid),
        .m1_rd_ready       (m1_rd_ready),
        .m1_rd_addr        (m1_rd_addr),
        .m1_rsp_valid      (m1_rsp_valid),
        .m1_rsp_data       (m1_rsp_data),
        .m1_wr_valid       (m1_wr_valid),
        .m1_wr_ready       (m1_wr_ready),
        .m1_wr_addr        (m1_wr_addr),
        .m1_wr_data        (m1_wr_data),
        .clear_start       (clear_start),
        .clear_busy        (clear_busy),
        .clear_done        (clear_done),
        .ram_address_write (ram_address_write),
        .ram_data_write    (ram_data_write),
        .ram_write_enable  (ram_write_enable),
        .ram_address_read  (ram_address_read),
        .ram_data_read     (ram_data_read)
    );

    // external RAM; fill_req preloads word i with 0x0000A + i so word 7 holds 0x00011
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 19'h0000A + 19'(i);
        end else if (ram_write_enable) begin
            mem[ram_address_write] <= ram_data_write;
        end
    end
    assign ram_data_read = mem[ram_address_read];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic fill();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        fill_req = 1'b0;
        clear_start = 1'b0;
        m0_rd_valid = 1'b0; m0_rd_addr = '0; m0_wr_valid = 1'b0; m0_wr_addr = '0; m0_wr_data = '0;
        m1_rd_valid = 1'b0; m1_rd_addr = '0; m1_wr_valid = 1'b0; m1_wr_addr = '0; m1_wr_data = '0;
        tick();
        fill();
        do_reset();

        check("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'h0);
        check("rst_m1_rsp_valid", 32'(m1_rsp_valid), 32'h0);
        check("rst_m0_rsp_data", 32'(m0_rsp_data), 32'h0);
        check("rst_m1_rsp_data", 32'(m1_rsp_data), 32'h0);
        check("rst_clear_busy", 32'(clear_busy), 32'h0);
        check("rst_clear_done", 32'(clear_done), 32'h0);
        check("rst_wr_enable", 32'(ram_write_enable), 32'h0);

        // write then read back through the other master
        m0_wr_valid = 1'b1; m0_wr_addr = 5'd3; m0_wr_data = 19'h1ABCD;
        #1;
        check("wr_m0_ready", 32'(m0_wr_ready), 32'h1);
        check("wr_enable", 32'(ram_write_enable), 32'h1);
        check("wr_addr", 32'(ram_address_write), 32'h3);
        check("wr_data", 32'(ram_data_write), 32'h1ABCD);
        tick();
        m0_wr_valid = 1'b0;
        m1_rd_valid = 1'b1; m1_rd_addr = 5'd3;
        #1;
        check("idle_wr_enable", 32'(ram_write_enable), 32'h0);
        check("rd_m1_ready", 32'(m1_rd_ready), 32'h1);
        check("rd_addr", 32'(ram_address_read), 32'h3);
        check("rd_no_early_valid", 32'(m1_rsp_valid), 32'h0);
        tick();
        m1_rd_valid = 1'b0;
        check("rd_rsp_valid", 32'(m1_rsp_valid), 32'h1);
        check("rd_rsp_data", 32'(m1_rsp_data), 32'h1ABCD);
        tick();
        check("rd_rsp_valid_drop", 32'(m1_rsp_valid), 32'h0);
        check("rd_rsp_data_hold", 32'(m1_rsp_data), 32'h1ABCD);

        // both masters contend on both ports from a fresh reset
        do_reset();
        m0_wr_valid = 1'b1; m0_wr_addr = 5'd1; m0_wr_data = 19'h00111;
        m1_wr_valid = 1'b1; m1_wr_addr = 5'd2; m1_wr_data = 19'h00222;
        m0_rd_valid = 1'b1; m0_rd_addr = 5'd1;
        m1_rd_valid = 1'b1; m1_rd_addr = 5'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_wr_m0_%0d", k), 32'(m0_wr_ready), 32'((k % 2) == 0));
            check($sformatf("rr_wr_m1_%0d", k), 32'(m1_wr_ready), 32'((k % 2) == 1));
            check($sformatf("rr_wr_addr_%0d", k), 32'(ram_address_write), (k % 2) == 0 ? 32'h1 : 32'h2);
            check($sformatf("rr_rd_m0_%0d", k), 32'(m0_rd_ready), 32'((k % 2) == 0));
            tick();
        end
        m0_wr_valid = 1'b0; m1_wr_valid = 1'b0;
        m0_rd_valid = 1'b0; m1_rd_valid = 1'b0;
        check("rr_mem1", 32'(mem[1]), 32'h00111);
        check("rr_mem2", 32'(mem[2]), 32'h00222);

        // same-address read and write in one cycle returns the old word
        fill();
        m0_wr_valid = 1'b1; m0_wr_addr = 5'd7; m0_wr_data = 19'h00055;
        m1_rd_valid = 1'b1; m1_rd_addr = 5'd7;
        #1;
        check("rw_wr_ready", 32'(m0_wr_ready), 32'h1);
        check("rw_rd_ready", 32'(m1_rd_ready), 32'h1);
        tick();
        m0_wr_valid = 1'b0;
        check("rw_old_valid", 32'(m1_rsp_valid), 32'h1);
        check("rw_old_data", 32'(m1_rsp_data), 32'h00011);
        tick();
        m1_rd_valid = 1'b0;
        check("rw_new_valid", 32'(m1_rsp_valid), 32'h1);
        check("rw_new_data", 32'(m1_rsp_data), 32'h00055);

        // clear beats a pending read, sweeps 32 words, then the read completes
        fill();
        m0_rd_valid = 1'b1; m0_rd_addr = 5'd5;
        clear_start = 1'b1;
        #1;
        check("clr_start_blocks_rd", 32'(m0_rd_ready), 32'h0);
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            clear_start = (i == 5);
            #1;
            check($sformatf("clr_busy_%0d", i), 32'(clear_busy), 32'h1);
            check($sformatf("clr_ready_%0d", i), 32'(m0_rd_ready), 32'h0);
            check($sformatf("clr_waddr_%0d", i), 32'(ram_address_write), 32'(i));
            check($sformatf("clr_done_low_%0d", i), 32'(clear_done), 32'h0);
            tick();
        end
        clear_start = 1'b0;
        check("clr_done_pulse", 32'(clear_done), 32'h1);
        check("clr_busy_end", 32'(clear_busy), 32'h0);
        check("clr_rd_ready_back", 32'(m0_rd_ready), 32'h1);
        tick();
        check("clr_done_once", 32'(clear_done), 32'h0);
        check("clr_pending_valid", 32'(m0_rsp_valid), 32'h1);
        check("clr_pending_data", 32'(m0_rsp_data), 32'h0);
        for (int i = 0; i < 32; i++) begin
            m0_rd_addr = 5'(i);
            tick();
            check($sformatf("clr_rd_valid_%0d", i), 32'(m0_rsp_valid), 32'h1);
            check($sformatf("clr_rd_data_%0d", i), 32'(m0_rsp_data), 32'h0);
        end
        m0_rd_valid = 1'b0;

        // reset while the sweep sits on word 10 aborts it silently
        fill();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        check("abort_no_write", 32'(ram_write_enable), 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_done_%0d", i), 32'(clear_done), 32'h0);
            check($sformatf("abort_busy_%0d", i), 32'(clear_busy), 32'h0);
            tick();
        end
        m0_rd_valid = 1'b1; m0_rd_addr = 5'd10;
        #1;
        check("abort_idle_ready", 32'(m0_rd_ready), 32'h1);
        tick();
        m0_rd_valid = 1'b0;
        check("abort_rd_word10", 32'(m0_rsp_data), 32'h00014);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("abort_mem_%0d", i), 32'(mem[i]), i < 10 ? 32'h0 : 32'h0000A + 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
